// File: rtl/signpipeadder_seg.sv
// Signed add/subtract unit whose carry chain is split into SEG-bit segments, one
// register stage per segment, with overflow/saturation and valid/ready flow control.
module signpipeadder_seg #(
  parameter int WIDTH    = 8,
  parameter int SEG      = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk1,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Carryout,
  output logic             Overflow,
  output logic             Saturated
);

  localparam int NSEG = (SEG < 1) ? 1 : (WIDTH + SEG - 1) / SEG;

  if (WIDTH < 2 || SEG < 1 || SEG > WIDTH) begin : g_param_chk
    $error("signpipeadder_seg: illegal WIDTH/SEG combination");
  end

  logic advance;

  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance & rst_n;

  for (genvar k = 0; k < NSEG; k++) begin : g_stg
    localparam int LO = k * SEG;
    localparam int HI = ((k + 1) * SEG < WIDTH) ? (k + 1) * SEG - 1 : WIDTH - 1;

    // ain/bin carry only the not-yet-added bits; s_full is the sum so far incl. this segment
    logic               vin;
    logic               cin;
    logic [WIDTH-1:LO]  ain;
    logic [WIDTH-1:LO]  bin;
    logic [HI:LO]       seg_s;
    logic [HI+1:LO]     cv;
    logic [HI:0]        s_full;

    if (k == 0) begin : g_src
      assign vin    = in_valid;
      assign ain    = A;
      assign bin    = sub ? ~B : B;
      assign cin    = sub ^ carry_in;
      assign s_full = seg_s;
    end else begin : g_src
      assign vin    = g_stg[k-1].g_reg.vld_q;
      assign ain    = g_stg[k-1].g_reg.a_q;
      assign bin    = g_stg[k-1].g_reg.b_q;
      assign cin    = g_stg[k-1].g_reg.c_q;
      assign s_full = {seg_s, g_stg[k-1].g_reg.s_q};
    end

    always_comb begin
      cv     = '0;
      seg_s  = '0;
      cv[LO] = cin;
      for (int i = LO; i <= HI; i++) begin
        seg_s[i] = ain[i] ^ bin[i] ^ cv[i];
        cv[i+1]  = (ain[i] & bin[i]) | (cv[i] & (ain[i] ^ bin[i]));
      end
    end

    if (k < NSEG - 1) begin : g_reg
      logic                vld_d, vld_q;
      logic                c_d, c_q;
      logic [WIDTH-1:HI+1] a_d, a_q, b_d, b_q;
      logic [HI:0]         s_d, s_q;

      always_comb begin
        vld_d = advance ? vin : vld_q;
        a_d   = ain[WIDTH-1:HI+1];
        b_d   = bin[WIDTH-1:HI+1];
        s_d   = s_full;
        c_d   = cv[HI+1];
      end

      // Data only loads for real operations; bubbles just clear the valid bit.
      always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
          vld_q <= 1'b0;
          a_q   <= '0;
          b_q   <= '0;
          s_q   <= '0;
          c_q   <= 1'b0;
        end else begin
          vld_q <= vld_d;
          if (advance && vin) begin
            a_q <= a_d;
            b_q <= b_d;
            s_q <= s_d;
            c_q <= c_d;
          end
        end
      end
    end else begin : g_out
      logic             vld_d, vld_q;
      logic             cout_d, cout_q;
      logic             ovf_d, ovf_q;
      logic             sat_d, sat_q;
      logic [WIDTH-1:0] sum_d, sum_q;

      // Overflow = carry into MSB xor carry out of MSB; clamp direction follows A's sign.
      always_comb begin
        vld_d  = advance ? vin : vld_q;
        cout_d = cv[HI+1];
        ovf_d  = cv[HI] ^ cv[HI+1];
        sat_d  = SATURATE & ovf_d;
        sum_d  = s_full;
        if (sat_d)
          sum_d = ain[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end

      always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
          vld_q  <= 1'b0;
          sum_q  <= '0;
          cout_q <= 1'b0;
          ovf_q  <= 1'b0;
          sat_q  <= 1'b0;
        end else begin
          vld_q <= vld_d;
          if (advance && vin) begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
            sat_q  <= sat_d;
          end
        end
      end
    end
  end

  assign out_valid = g_stg[NSEG-1].g_out.vld_q;
  assign Sum       = g_stg[NSEG-1].g_out.sum_q;
  assign Carryout  = g_stg[NSEG-1].g_out.cout_q;
  assign Overflow  = g_stg[NSEG-1].g_out.ovf_q;
  assign Saturated = g_stg[NSEG-1].g_out.sat_q;

endmodule

// File: tb/tb_signpipeadder_seg.sv
// Directed + constrained-random bench for signpipeadder_seg across several
// WIDTH/SEG/SATURATE configurations.
module tb_signpipeadder_seg;

  logic clk1  = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk1 = ~clk1;

  int n_chk  = 0;
  int n_pass = 0;

  // WIDTH=8 SEG=4, shared stimulus: dut0 wraps, dut1 saturates
  logic [7:0] A8, B8;
  logic       sub8, cin8, vin8, ordy8;
  logic       rdy0, ov0, co0, of0, st0;
  logic [7:0] sum0;
  logic       rdy1, ov1, co1, of1, st1;
  logic [7:0] sum1;
  // WIDTH=9 SEG=4 saturating (uneven top segment)
  logic [8:0] A9, B9, sum2;
  logic       sub9, cin9, vin9, ordy9, rdy2, ov2, co2, of2, st2;
  // WIDTH=16 SEG=16 wrapping (single stage)
  logic [15:0] A16, B16, sum3;
  logic        sub16, cin16, vin16, ordy16, rdy3, ov3, co3, of3, st3;

  signpipeadder_seg #(.WIDTH(8), .SEG(4), .SATURATE(1'b0)) u_dut0 (
    .clk1(clk1), .rst_n(rst_n), .in_valid(vin8), .in_ready(rdy0), .A(A8), .B(B8),
    .sub(sub8), .carry_in(cin8), .out_valid(ov0), .out_ready(ordy8), .Sum(sum0),
    .Carryout(co0), .Overflow(of0), .Saturated(st0));

  signpipeadder_seg #(.WIDTH(8), .SEG(4), .SATURATE(1'b1)) u_dut1 (
    .clk1(clk1), .rst_n(rst_n), .in_valid(vin8), .in_ready(rdy1), .A(A8), .B(B8),
    .sub(sub8), .carry_in(cin8), .out_valid(ov1), .out_ready(ordy8), .Sum(sum1),
    .Carryout(co1), .Overflow(of1), .Saturated(st1));

  signpipeadder_seg #(.WIDTH(9), .SEG(4), .SATURATE(1'b1)) u_dut2 (
    .clk1(clk1), .rst_n(rst_n), .in_valid(vin9), .in_ready(rdy2), .A(A9), .B(B9),
    .sub(sub9), .carry_in(cin9), .out_valid(ov2), .out_ready(ordy9), .Sum(sum2),
    .Carryout(co2), .Overflow(of2), .Saturated(st2));

  signpipeadder_seg #(.WIDTH(16), .SEG(16), .SATURATE(1'b0)) u_dut3 (
    .clk1(clk1), .rst_n(rst_n), .in_valid(vin16), .in_ready(rdy3), .A(A16), .B(B16),
    .sub(sub16), .carry_in(cin16), .out_valid(ov3), .out_ready(ordy16), .Sum(sum3),
    .Carryout(co3), .Overflow(of3), .Saturated(st3));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Reference: full-width add, overflow from operand/result signs. Packs {sat,ovf,cout,sum}.
  function automatic logic [63:0] model(input int w, input bit satp, input logic [63:0] a,
                                        input logic [63:0] b, input bit s, input bit ci);
    logic [63:0] m, be, full, sum;
    bit sa, sb, ss, ovf, co, st;
    m    = (64'd1 << w) - 64'd1;
    be   = (s ? ~b : b) & m;
    full = (a & m) + be + 64'(s ^ ci);
    sum  = full & m;
    co   = full[w];
    sa   = a[w-1];
    sb   = be[w-1];
    ss   = sum[w-1];
    ovf  = (sa == sb) && (ss != sa);
    st   = satp && ovf;
    if (st) sum = sa ? (64'd1 << (w - 1)) : ((64'd1 << (w - 1)) - 64'd1);
    return sum | (64'(co) << w) | (64'(ovf) << (w + 1)) | (64'(st) << (w + 2));
  endfunction

  function automatic logic [63:0] rnd_opnd(input int w);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    case ($urandom_range(7))
      0:       return 64'd0;
      1:       return (64'd1 << (w - 1)) - 64'd1;
      2:       return 64'd1 << (w - 1);
      3:       return m;
      default: return {$urandom, $urandom} & m;
    endcase
  endfunction

  // One isolated op through the 8-bit pair, checking exact 2-cycle latency.
  task automatic dir(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input bit s, input bit ci, input logic [10:0] e0, input logic [10:0] e1);
    @(negedge clk1);
    A8 = a; B8 = b; sub8 = s; cin8 = ci; vin8 = 1'b1;
    @(negedge clk1);
    vin8 = 1'b0;
    chk({tag, "_early"}, ov0, 0);
    @(negedge clk1);
    chk({tag, "_vld"}, ov0, 1);
    chk({tag, "_wrap"}, {st0, of0, co0, sum0}, e0);
    chk({tag, "_sat"}, {st1, of1, co1, sum1}, e1);
  endtask

  task automatic rand_run(input int dut, input int w, input bit satp, input int nops);
    logic [63:0] q[$];
    logic [63:0] a, b, res;
    bit s, ci, v, r, ov, rdy;
    int sent = 0;
    int cyc  = 0;
    while ((sent < nops || q.size() > 0) && cyc < 20000) begin
      @(negedge clk1);
      cyc++;
      r  = ($urandom_range(3) != 0);
      v  = (sent < nops) && ($urandom_range(3) != 0);
      a  = rnd_opnd(w);
      b  = rnd_opnd(w);
      s  = 1'($urandom_range(1));
      ci = 1'($urandom_range(1));
      if (dut == 2) begin
        A9 = a[8:0]; B9 = b[8:0]; sub9 = s; cin9 = ci; vin9 = v; ordy9 = r;
      end else begin
        A16 = a[15:0]; B16 = b[15:0]; sub16 = s; cin16 = ci; vin16 = v; ordy16 = r;
      end
      #1;
      if (dut == 2) begin
        ov = ov2; rdy = rdy2; res = 64'({st2, of2, co2, sum2});
      end else begin
        ov = ov3; rdy = rdy3; res = 64'({st3, of3, co3, sum3});
      end
      if (ov && r) begin
        if (q.size() == 0) chk($sformatf("rnd%0d_spurious", dut), ov, 0);
        else chk($sformatf("rnd%0d_res", dut), res, q.pop_front());
      end
      if (v && rdy) begin
        q.push_back(model(w, satp, a, b, s, ci));
        sent++;
      end
    end
    chk($sformatf("rnd%0d_sent", dut), sent, nops);
    chk($sformatf("rnd%0d_drained", dut), q.size(), 0);
    vin9 = 1'b0; ordy9 = 1'b1; vin16 = 1'b0; ordy16 = 1'b1;
  endtask

  logic [7:0] tA [6] = '{8'd10, 8'd50, 8'h10, 8'd127, 8'd0, 8'h9C};
  logic [7:0] tB [6] = '{8'd20, 8'hF9, 8'h20, 8'd1,   8'd0, 8'hCE};
  bit         tS [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  bit         tC [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [7:0] tE0[6] = '{8'd30, 8'h2C, 8'hF0, 8'h80, 8'hFF, 8'h6A};
  logic [7:0] tE1[6] = '{8'd30, 8'h2C, 8'hF0, 8'h7F, 8'hFF, 8'h80};
  logic [7:0] held0;
  int         idx, ret;
  bit         stall;

  initial begin
    A8 = '0; B8 = '0; sub8 = 0; cin8 = 0; vin8 = 0; ordy8 = 1;
    A9 = '0; B9 = '0; sub9 = 0; cin9 = 0; vin9 = 0; ordy9 = 1;
    A16 = '0; B16 = '0; sub16 = 0; cin16 = 0; vin16 = 0; ordy16 = 1;

    #3;
    chk("rst_ov", ov0, 0);
    chk("rst_rdy", rdy0, 0);
    chk("rst_out0", {st0, of0, co0, sum0}, 0);
    chk("rst_out1", {st1, of1, co1, sum1}, 0);
    repeat (2) @(negedge clk1);
    rst_n = 1'b1;
    #1 chk("rel_rdy", rdy0, 1);

    dir("t1",   8'd100, 8'd27, 1'b0, 1'b0, 11'h07F, 11'h07F);
    dir("t2",   8'd100, 8'd28, 1'b0, 1'b0, 11'h280, 11'h67F);
    dir("t3",   8'h80,  8'h01, 1'b1, 1'b0, 11'h37F, 11'h780);
    dir("t3b",  8'd5,   8'd3,  1'b1, 1'b1, 11'h101, 11'h101);
    dir("negov",8'h80,  8'hFF, 1'b0, 1'b0, 11'h37F, 11'h780);
    dir("wrap0",8'hFF,  8'h01, 1'b0, 1'b0, 11'h100, 11'h100);
    @(negedge clk1);
    chk("idle_ov", ov0, 0);
    chk("idle_hold", sum0, 8'h00);

    // Back-to-back stream with a 3-cycle consumer stall.
    idx = 0; ret = 0;
    for (int c = 0; c < 40 && ret < 6; c++) begin
      @(negedge clk1);
      stall = (c >= 3 && c <= 5);
      ordy8 = !stall;
      if (idx < 6) begin
        A8 = tA[idx]; B8 = tB[idx]; sub8 = tS[idx]; cin8 = tC[idx]; vin8 = 1'b1;
      end else vin8 = 1'b0;
      #1;
      if (stall) begin
        chk("s4_ov_stall", ov0, 1);
        chk("s4_rdy_stall", rdy0, 0);
        if (c > 3) chk("s4_hold", sum0, held0);
        held0 = sum0;
      end
      if (ov0 && ordy8) begin
        chk($sformatf("s4_res0_%0d", ret), sum0, tE0[ret]);
        chk($sformatf("s4_res1_%0d", ret), sum1, tE1[ret]);
        ret++;
      end
      if (vin8 && rdy0) idx++;
    end
    vin8 = 1'b0; ordy8 = 1'b1;
    chk("s4_count", ret, 6);
    @(negedge clk1);
    chk("s4_no_dup", ov0, 0);

    // Async reset with two ops in flight.
    @(negedge clk1);
    A8 = 8'd100; B8 = 8'd28; sub8 = 0; cin8 = 0; vin8 = 1'b1;
    @(negedge clk1);
    A8 = 8'd5; B8 = 8'd3;
    @(negedge clk1);
    vin8 = 1'b0;
    chk("r5_inflight", ov0, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("r5_ov", ov0, 0);
    chk("r5_sum", sum0, 0);
    chk("r5_flags", {st1, of1, co1, sum1}, 0);
    chk("r5_rdy", rdy0, 0);
    repeat (2) @(negedge clk1);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk1);
      chk("r5_stale", ov0, 0);
    end
    chk("r5_rdy_rel", rdy0, 1);

    rand_run(2, 9, 1'b1, 1000);
    rand_run(3, 16, 1'b0, 1000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
